// File: rtl/lsu_if.sv
// Request/response and memory-bus signal bundle for the load/store unit.
// The LSU connects through the slave modport; the pipeline/memory side uses master.
interface lsu_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
);
    logic              req_valid_in;
    logic              req_ready_out;
    logic              read_in;
    logic              write_in;
    logic [1:0]        width_in;
    logic              zero_extend_in;
    logic [XLEN-1:0]   addr_in;
    logic [XLEN-1:0]   wdata_in;
    logic [RD_W-1:0]   rd_in;
    logic              rd_write_in;
    logic              flush_in;

    logic              resp_valid_out;
    logic [RD_W-1:0]   rd_out;
    logic              rd_write_out;
    logic [XLEN-1:0]   rd_value_out;
    logic              misalign_out;

    logic              bus_req_out;
    logic              bus_we_out;
    logic [XLEN-1:0]   bus_addr_out;
    logic [XLEN/8-1:0] bus_wmask_out;
    logic [XLEN-1:0]   bus_wdata_out;
    logic              bus_ack_in;
    logic [XLEN-1:0]   bus_rdata_in;

    modport slave (
        input  req_valid_in, read_in, write_in, width_in, zero_extend_in, addr_in,
        input  wdata_in, rd_in, rd_write_in, flush_in, bus_ack_in, bus_rdata_in,
        output req_ready_out, resp_valid_out, rd_out, rd_write_out, rd_value_out,
        output misalign_out, bus_req_out, bus_we_out, bus_addr_out, bus_wmask_out,
        output bus_wdata_out
    );

    modport master (
        output req_valid_in, read_in, write_in, width_in, zero_extend_in, addr_in,
        output wdata_in, rd_in, rd_write_in, flush_in, bus_ack_in, bus_rdata_in,
        input  req_ready_out, resp_valid_out, rd_out, rd_write_out, rd_value_out,
        input  misalign_out, bus_req_out, bus_we_out, bus_addr_out, bus_wmask_out,
        input  bus_wdata_out
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding memory access, ALU pass-through, lane steering.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave io
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OffW = $clog2(NB);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StBus, StDrain} state_e;

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic              misalign_q, misalign_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              rd_write_q, rd_write_d;
    logic [XLEN-1:0]   rd_value_q, rd_value_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [NB-1:0]     bus_wmask_q, bus_wmask_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;

    // Context of the outstanding access, needed when the ack arrives.
    logic [1:0]        size_q, size_d;
    logic [OffW-1:0]   off_q, off_d;
    logic              zext_q, zext_d;
    logic              is_load_q, is_load_d;
    logic [RD_W-1:0]   rd_pend_q, rd_pend_d;
    logic              wb_pend_q, wb_pend_d;

    logic              accept;
    logic [1:0]        req_size;
    logic [OffW-1:0]   req_off;
    logic [OffW-1:0]   lo_mask;
    logic [OffW-1:0]   req_off_al;
    logic              req_misaligned;
    logic [NB-1:0]     st_mask;
    logic [XLEN-1:0]   st_data;

    logic [XLEN-1:0]        ld_shift;
    logic [XLEN-1:0]        ld_left;
    logic [6:0]             ld_shamt;
    logic [XLEN-1:0]        ld_zext;
    logic signed [XLEN-1:0] ld_sext;
    logic [XLEN-1:0]        ld_value;

    assign accept = io.req_valid_in && !io.flush_in && (state_q == StIdle);

    // Request decode: effective size, natural-alignment truncation, store lane steering.
    always_comb begin
        req_size = io.width_in;
        if (XLEN == 32 && io.width_in == 2'd3) begin
            req_size = 2'd2;
        end
        req_off        = io.addr_in[OffW-1:0];
        lo_mask        = OffW'((4'd1 << req_size) - 4'd1);
        req_misaligned = |(req_off & lo_mask);
        req_off_al     = req_off & ~lo_mask;

        st_mask = '0;
        st_data = '0;
        case (req_size)
            2'd0: begin
                st_mask = NB'(1) << req_off_al;
                st_data = {NB{io.wdata_in[7:0]}};
            end
            2'd1: begin
                st_mask = NB'(3) << req_off_al;
                st_data = {(XLEN/16){io.wdata_in[15:0]}};
            end
            2'd2: begin
                st_mask = NB'(15) << req_off_al;
                st_data = {(XLEN/32){io.wdata_in[31:0]}};
            end
            default: begin
                st_mask = '1;
                st_data = io.wdata_in;
            end
        endcase
    end

    // Load extraction: move the addressed lanes to bit 0, then extend from the access width.
    always_comb begin
        ld_shift = io.bus_rdata_in >> {off_q, 3'b000};
        ld_shamt = 7'(XLEN) - (7'd8 << size_q);
        ld_left  = ld_shift << ld_shamt;
        ld_zext  = ld_left >> ld_shamt;
        ld_sext  = $signed(ld_left) >>> ld_shamt;
        ld_value = zext_q ? ld_zext : $unsigned(ld_sext);
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        misalign_d   = 1'b0;
        rd_d         = rd_q;
        rd_write_d   = 1'b0;
        rd_value_d   = rd_value_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wmask_d  = bus_wmask_q;
        bus_wdata_d  = bus_wdata_q;
        size_d       = size_q;
        off_d        = off_q;
        zext_d       = zext_q;
        is_load_d    = is_load_q;
        rd_pend_d    = rd_pend_q;
        wb_pend_d    = wb_pend_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!io.read_in && !io.write_in) begin
                        resp_valid_d = 1'b1;
                        rd_d         = io.rd_in;
                        rd_write_d   = io.rd_write_in;
                        rd_value_d   = io.addr_in;
                    end else if (TrapEn && req_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = StBus;
                        bus_req_d   = 1'b1;
                        bus_we_d    = io.write_in;
                        bus_addr_d  = {io.addr_in[XLEN-1:OffW], OffW'(0)};
                        bus_wmask_d = io.write_in ? st_mask : '0;
                        bus_wdata_d = st_data;
                        size_d      = req_size;
                        off_d       = req_off_al;
                        zext_d      = io.zero_extend_in;
                        is_load_d   = !io.write_in;
                        rd_pend_d   = io.rd_in;
                        wb_pend_d   = io.rd_write_in && !io.write_in;
                    end
                end
            end
            StBus: begin
                if (io.flush_in) begin
                    // A flush coinciding with the ack simply drops the response.
                    if (io.bus_ack_in) begin
                        bus_req_d = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (io.bus_ack_in) begin
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    rd_d         = rd_pend_q;
                    rd_write_d   = wb_pend_q;
                    if (is_load_q) begin
                        rd_value_d = ld_value;
                    end
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (io.bus_ack_in) begin
                    bus_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            rd_q         <= '0;
            rd_write_q   <= 1'b0;
            rd_value_q   <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wmask_q  <= '0;
            bus_wdata_q  <= '0;
            size_q       <= '0;
            off_q        <= '0;
            zext_q       <= 1'b0;
            is_load_q    <= 1'b0;
            rd_pend_q    <= '0;
            wb_pend_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            misalign_q   <= misalign_d;
            rd_q         <= rd_d;
            rd_write_q   <= rd_write_d;
            rd_value_q   <= rd_value_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wmask_q  <= bus_wmask_d;
            bus_wdata_q  <= bus_wdata_d;
            size_q       <= size_d;
            off_q        <= off_d;
            zext_q       <= zext_d;
            is_load_q    <= is_load_d;
            rd_pend_q    <= rd_pend_d;
            wb_pend_q    <= wb_pend_d;
        end
    end

    assign io.req_ready_out  = (state_q == StIdle);
    assign io.resp_valid_out = resp_valid_q;
    assign io.rd_out         = rd_q;
    assign io.rd_write_out   = rd_write_q;
    assign io.rd_value_out   = rd_value_q;
    assign io.misalign_out   = TrapEn & misalign_q;
    assign io.bus_req_out    = bus_req_q;
    assign io.bus_we_out     = bus_we_q;
    assign io.bus_addr_out   = bus_addr_q;
    assign io.bus_wmask_out  = bus_wmask_q;
    assign io.bus_wdata_out  = bus_wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu (XLEN=64): directed literal cases plus random traffic against a
// transaction-level model of the unit's rules.
`timescale 1ns/1ps
module tb_lsu;
    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.XLEN(XLEN), .RD_W(RD_W)) bus_if ();
    lsu #(.XLEN(XLEN), .RD_W(RD_W)) dut (.clk(clk), .rst(rst), .io(bus_if));

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endfunction

    // Gather the addressed bytes, then extend from the access width.
    function automatic logic [63:0] load_val(logic [63:0] rdata, int off, int size, bit zext);
        logic [63:0] v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!zext && size < 8 && v[8*size-1])
            for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_live = 1'b0, m_busy = 1'b0, m_killed = 1'b0;
    bit          e_ready, e_resp, e_mis, e_breq, e_bwe, e_rdw, e_post_rst;
    logic [63:0] e_val, e_baddr, e_bwdata;
    logic [7:0]  e_bmask;
    logic [4:0]  e_rd;
    int          e_kind;  // 0 pass-through, 1 load, 2 store
    int          p_off, p_size, m_sz, m_off8;
    bit          p_zext, p_load, p_rdw;
    logic [4:0]  p_rd;

    always @(posedge clk) begin
        e_resp     = 1'b0;
        e_mis      = 1'b0;
        e_post_rst = 1'b0;
        if (rst) begin
            m_live = 1'b1; m_busy = 1'b0; m_killed = 1'b0;
            e_breq = 1'b0; e_rd = '0; e_rdw = 1'b0; e_val = '0; e_bmask = '0;
            e_post_rst = 1'b1;
        end else if (m_live) begin
            if (!m_busy) begin
                if (bus_if.req_valid_in && !bus_if.flush_in) begin
                    if (!bus_if.read_in && !bus_if.write_in) begin
                        e_resp = 1'b1; e_kind = 0; e_val = bus_if.addr_in;
                        e_rd = bus_if.rd_in; e_rdw = bus_if.rd_write_in;
                    end else begin
                        m_sz   = 1 << bus_if.width_in;
                        m_off8 = int'(bus_if.addr_in % 8);
                        if (TrapEn && (m_off8 % m_sz) != 0) begin
                            e_mis = 1'b1;
                        end else begin
                            m_busy  = 1'b1; m_killed = 1'b0;
                            e_breq  = 1'b1;
                            e_bwe   = bus_if.write_in;
                            e_baddr = bus_if.addr_in - 64'(m_off8);
                            p_off   = m_off8 - (m_off8 % m_sz);
                            p_size  = m_sz;
                            p_load  = !bus_if.write_in;
                            p_zext  = bus_if.zero_extend_in;
                            p_rd    = bus_if.rd_in;
                            p_rdw   = bus_if.rd_write_in;
                            for (int b = 0; b < 8; b++) begin
                                e_bmask[b] = (b >= p_off) && (b < p_off + p_size);
                                e_bwdata[8*b +: 8] = bus_if.wdata_in[8*(b % p_size) +: 8];
                            end
                        end
                    end
                end
            end else if (bus_if.bus_ack_in) begin
                m_busy = 1'b0;
                e_breq = 1'b0;
                if (!m_killed && !bus_if.flush_in) begin
                    e_resp = 1'b1;
                    e_rd   = p_rd;
                    e_rdw  = p_load ? p_rdw : 1'b0;
                    e_kind = p_load ? 1 : 2;
                    if (p_load) e_val = load_val(bus_if.bus_rdata_in, p_off, p_size, p_zext);
                end
                m_killed = 1'b0;
            end else if (bus_if.flush_in) begin
                m_killed = 1'b1;
            end
        end
        e_ready = !m_busy;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("ready", 64'(bus_if.req_ready_out), 64'(e_ready));
            check("resp_valid", 64'(bus_if.resp_valid_out), 64'(e_resp));
            check("misalign", 64'(bus_if.misalign_out), 64'(e_mis));
            check("bus_req", 64'(bus_if.bus_req_out), 64'(e_breq));
            if (e_resp) begin
                check("rd", 64'(bus_if.rd_out), 64'(e_rd));
                check("rd_write", 64'(bus_if.rd_write_out), 64'(e_rdw));
                if (e_kind != 2) check("rd_value", bus_if.rd_value_out, e_val);
            end
            if (e_breq) begin
                check("bus_we", 64'(bus_if.bus_we_out), 64'(e_bwe));
                check("bus_addr", bus_if.bus_addr_out, e_baddr);
                if (e_bwe) begin
                    check("bus_wmask", 64'(bus_if.bus_wmask_out), 64'(e_bmask));
                    check("bus_wdata", bus_if.bus_wdata_out, e_bwdata);
                end
            end
            if (e_post_rst) begin
                check("rst_rd", 64'(bus_if.rd_out), 64'(e_rd));
                check("rst_rd_write", 64'(bus_if.rd_write_out), 64'(e_rdw));
                check("rst_rd_value", bus_if.rd_value_out, e_val);
                check("rst_wmask", 64'(bus_if.bus_wmask_out), 64'(e_bmask));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_if.req_valid_in   = 1'b0;
        bus_if.read_in        = 1'b0;
        bus_if.write_in       = 1'b0;
        bus_if.width_in       = 2'd0;
        bus_if.zero_extend_in = 1'b0;
        bus_if.addr_in        = '0;
        bus_if.wdata_in       = '0;
        bus_if.rd_in          = '0;
        bus_if.rd_write_in    = 1'b0;
        bus_if.flush_in       = 1'b0;
        bus_if.bus_ack_in     = 1'b0;
        bus_if.bus_rdata_in   = '0;
    endtask

    task automatic drive_req(bit rd_en, bit wr_en, logic [1:0] w, bit zx, logic [63:0] a,
                             logic [63:0] wd, logic [4:0] r, bit rw);
        bus_if.req_valid_in   = 1'b1;
        bus_if.read_in        = rd_en;
        bus_if.write_in       = wr_en;
        bus_if.width_in       = w;
        bus_if.zero_extend_in = zx;
        bus_if.addr_in        = a;
        bus_if.wdata_in       = wd;
        bus_if.rd_in          = r;
        bus_if.rd_write_in    = rw;
    endtask

    int wait_cnt = 0;
    int op;

    initial begin
        drive_idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("init_ready", 64'(bus_if.req_ready_out), 64'd1);
        check("init_bus_req", 64'(bus_if.bus_req_out), 64'd0);
        check("init_resp", 64'(bus_if.resp_valid_out), 64'd0);
        check("init_rd_value", bus_if.rd_value_out, 64'd0);

        // Store byte at 0x1003, ack after two bus cycles.
        drive_req(1'b0, 1'b1, 2'd0, 1'b0, 64'h1003, 64'hAB, 5'd3, 1'b1);
        tick(); drive_idle();
        check("sb_bus_req", 64'(bus_if.bus_req_out), 64'd1);
        check("sb_we", 64'(bus_if.bus_we_out), 64'd1);
        check("sb_addr", bus_if.bus_addr_out, 64'h1000);
        check("sb_mask", 64'(bus_if.bus_wmask_out), 64'h08);
        check("sb_wdata", bus_if.bus_wdata_out, 64'hABAB_ABAB_ABAB_ABAB);
        check("sb_ready_busy", 64'(bus_if.req_ready_out), 64'd0);
        tick();
        check("sb_hold_mask", 64'(bus_if.bus_wmask_out), 64'h08);
        bus_if.bus_ack_in = 1'b1;
        tick(); bus_if.bus_ack_in = 1'b0;
        check("sb_resp", 64'(bus_if.resp_valid_out), 64'd1);
        check("sb_rd_write", 64'(bus_if.rd_write_out), 64'd0);
        check("sb_bus_req_done", 64'(bus_if.bus_req_out), 64'd0);

        // Load half at 0x2006, sign- then zero-extended.
        for (int z = 0; z < 2; z++) begin
            drive_req(1'b1, 1'b0, 2'd1, z[0], 64'h2006, 64'd0, 5'd9, 1'b1);
            tick(); drive_idle();
            bus_if.bus_ack_in   = 1'b1;
            bus_if.bus_rdata_in = 64'h8001_1234_5678_9ABC;
            tick(); drive_idle();
            check("lh_resp", 64'(bus_if.resp_valid_out), 64'd1);
            check("lh_ready_with_resp", 64'(bus_if.req_ready_out), 64'd1);
            check("lh_rd", 64'(bus_if.rd_out), 64'd9);
            check("lh_value", bus_if.rd_value_out,
                  (z == 0) ? 64'hFFFF_FFFF_FFFF_8001 : 64'h0000_0000_0000_8001);
        end

        // Load word at misaligned 0x1002.
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'd0, 5'd4, 1'b1);
        tick(); drive_idle();
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_pulse", 64'(bus_if.misalign_out), 64'd1);
        check("lw_mis_no_bus", 64'(bus_if.bus_req_out), 64'd0);
        check("lw_mis_no_resp", 64'(bus_if.resp_valid_out), 64'd0);
        tick();
        check("lw_mis_one_cycle", 64'(bus_if.misalign_out), 64'd0);
        check("lw_mis_still_no_bus", 64'(bus_if.bus_req_out), 64'd0);
`else
        check("lw_addr", bus_if.bus_addr_out, 64'h1000);
        check("lw_bus_req", 64'(bus_if.bus_req_out), 64'd1);
        bus_if.bus_ack_in   = 1'b1;
        bus_if.bus_rdata_in = 64'h0123_4567_DEAD_BEEF;
        tick(); drive_idle();
        check("lw_value", bus_if.rd_value_out, 64'hFFFF_FFFF_DEAD_BEEF);
        check("lw_no_mis", 64'(bus_if.misalign_out), 64'd0);
`endif

        // Load flushed one cycle after accept, ack three cycles after the flush.
        drive_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h3000, 64'd0, 5'd2, 1'b1);
        tick(); drive_idle();
        bus_if.flush_in = 1'b1;
        tick(); bus_if.flush_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_bus_req_held", 64'(bus_if.bus_req_out), 64'd1);
            tick();
        end
        check("drain_bus_req_held", 64'(bus_if.bus_req_out), 64'd1);
        bus_if.bus_ack_in = 1'b1;
        tick(); bus_if.bus_ack_in = 1'b0;
        check("drain_no_resp", 64'(bus_if.resp_valid_out), 64'd0);
        check("drain_ready", 64'(bus_if.req_ready_out), 64'd1);
        check("drain_bus_req_done", 64'(bus_if.bus_req_out), 64'd0);

        // A request presented together with flush is not accepted.
        drive_req(1'b0, 1'b0, 2'd0, 1'b0, 64'h77, 64'd0, 5'd1, 1'b1);
        bus_if.flush_in = 1'b1;
        tick(); drive_idle();
        check("flush_req_dropped", 64'(bus_if.resp_valid_out), 64'd0);

        // Reset in the middle of a bus access, then a pass-through.
        drive_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'd0, 5'd6, 1'b1);
        tick(); drive_idle();
        check("midbus_req", 64'(bus_if.bus_req_out), 64'd1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        check("mr_bus_req", 64'(bus_if.bus_req_out), 64'd0);
        check("mr_ready", 64'(bus_if.req_ready_out), 64'd1);
        check("mr_resp", 64'(bus_if.resp_valid_out), 64'd0);
        check("mr_rd_write", 64'(bus_if.rd_write_out), 64'd0);
        check("mr_misalign", 64'(bus_if.misalign_out), 64'd0);
        check("mr_rd_value", bus_if.rd_value_out, 64'd0);
        check("mr_rd", 64'(bus_if.rd_out), 64'd0);
        check("mr_wmask", 64'(bus_if.bus_wmask_out), 64'd0);
        drive_req(1'b0, 1'b0, 2'd0, 1'b0, 64'h55, 64'd0, 5'd7, 1'b1);
        tick(); drive_idle();
        check("pt_resp", 64'(bus_if.resp_valid_out), 64'd1);
        check("pt_value", bus_if.rd_value_out, 64'h55);
        check("pt_rd", 64'(bus_if.rd_out), 64'd7);
        check("pt_no_bus", 64'(bus_if.bus_req_out), 64'd0);
        tick();
        check("pt_strobe_one_cycle", 64'(bus_if.resp_valid_out), 64'd0);

        // Random traffic with a random-latency memory.
        for (int c = 0; c < 4000; c++) begin
            op = $urandom_range(0, 2);
            bus_if.req_valid_in   = ($urandom_range(0, 3) != 0);
            bus_if.read_in        = (op == 1);
            bus_if.write_in       = (op == 2);
            bus_if.width_in       = 2'($urandom_range(0, 3));
            bus_if.zero_extend_in = 1'($urandom_range(0, 1));
            bus_if.addr_in        = {32'($urandom), 32'($urandom)};
            bus_if.wdata_in       = {32'($urandom), 32'($urandom)};
            bus_if.rd_in          = 5'($urandom_range(0, 31));
            bus_if.rd_write_in    = 1'($urandom_range(0, 1));
            bus_if.flush_in       = ($urandom_range(0, 9) == 0);
            rst                   = ($urandom_range(0, 199) == 0);
            bus_if.bus_rdata_in   = {32'($urandom), 32'($urandom)};
            if (m_busy && wait_cnt == 0) begin
                bus_if.bus_ack_in = 1'b1;
                wait_cnt = $urandom_range(0, 3);
            end else begin
                bus_if.bus_ack_in = 1'b0;
                if (wait_cnt > 0) wait_cnt--;
            end
            tick();
        end
        drive_idle();
        rst = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters: XLEN, default 64, data/address width, legal values 32 or 64; RD_W, default 5, destination register index width.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  the block's one clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid_in  in  1  request present.
- req_ready_out  out  1  request accepted when high together with req_valid_in.
- read_in, write_in  in  1  load / store; both low = ALU pass-through.
- width_in  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- zero_extend_in  in  1  zero-extend the load result.
- addr_in  in  XLEN  effective address, or ALU result for pass-through.
- wdata_in  in  XLEN  store data.
- rd_in  in  RD_W  destination register.
- rd_write_in  in  1  writeback enable.
- flush_in  in  1  kill the current or incoming request.
- resp_valid_out  out  1  one-cycle response strobe.
- rd_out  out  RD_W  destination register.
- rd_write_out  out  1  writeback enable.
- rd_value_out  out  XLEN  writeback value.
- misalign_out  out  1  misaligned-access exception strobe.
- bus_req_out  out  1  memory request, held until bus_ack_in.
- bus_we_out  out  1  memory write.
- bus_addr_out  out  XLEN  address aligned to XLEN/8 bytes.
- bus_wmask_out  out  XLEN/8  byte-lane write enables.
- bus_wdata_out  out  XLEN  lane-replicated store data.
- bus_ack_in  in  1  memory completion.
- bus_rdata_in  in  XLEN  load data, valid with bus_ack_in.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUS (request outstanding), DRAIN (request outstanding, already flushed).
REQ-004 req_ready_out SHALL be high only in IDLE; a request arriving in the same cycle as flush_in SHALL NOT be accepted.
REQ-005 An accepted pass-through SHALL give resp_valid_out=1 next cycle with rd_value_out=addr_in; the FSM stays in IDLE.
REQ-006 An accepted load/store SHALL register bus_req_out=1 next cycle and enter BUS; all bus_* outputs SHALL hold steady until the cycle bus_ack_in=1.
REQ-007 On bus_ack_in in BUS, the next cycle SHALL give resp_valid_out=1, rd_out/rd_write_out as captured, and return to IDLE. Minimum accept-to-response latency is 2 cycles; resp_valid_out and req_ready_out are both high in that cycle.
REQ-008 Store lanes: off = addr[log2(XLEN/8)-1:0].
- Byte: mask = 1<<off, data = byte replicated.
- Half: mask = 2'b11<<off, data = half replicated.
- Word: mask = 4'hF<<off, data = word replicated.
- Double: all lanes.
REQ-009 Load extraction SHALL select the addressed lane(s) of bus_rdata_in, then sign- or zero-extend to XLEN per zero_extend_in. Word on XLEN=32 and double ignore zero_extend_in.
REQ-010 Stores SHALL respond with rd_write_out=0.
REQ-011 flush_in in BUS SHALL move the FSM to DRAIN. DRAIN SHALL keep bus_req_out asserted until bus_ack_in, then return to IDLE with no response.
REQ-012 width_in=11 with XLEN=32 SHALL be treated as word.

Reset
REQ-013 rst SHALL force, on the next clk edge: IDLE, bus_req_out=0, resp_valid_out=0, rd_write_out=0, misalign_out=0, rd_value_out=0, rd_out=0, bus_wmask_out=0. This applies in any state, including mid-BUS; any outstanding bus transaction is abandoned and the memory side SHALL tolerate the abandoned request.

Configuration
REQ-014 Macro LSU_MISALIGN_TRAP_EN.
- Defined: an access whose address is not a multiple of its size SHALL produce misalign_out=1 for one cycle, one cycle after acceptance. There SHALL be no bus request, no resp_valid_out, and the FSM stays in IDLE.
- Undefined: misaligned addresses SHALL be truncated to natural alignment and processed normally; misalign_out SHALL be tied 0.

Verification (XLEN=64)
REQ-015 Store byte, addr 0x1003, wdata 0xAB -> bus_wmask_out=0x08, bus_wdata_out=0xABABABABABABABAB, bus_we_out=1, bus_addr_out=0x1000; ack after 2 cycles -> resp_valid_out=1, rd_write_out=0.
REQ-016 Load half, addr 0x2006, bus_rdata_in[63:48]=0x8001. zero_extend_in=0 -> rd_value_out=0xFFFFFFFFFFFF8001; zero_extend_in=1 -> 0x0000000000008001.
REQ-017 Load word, addr 0x1002, LSU_MISALIGN_TRAP_EN defined -> misalign_out pulse 1 cycle after accept, bus_req_out stays 0. Macro undefined -> bus_addr_out=0x1000, word taken from lanes 3:0.
REQ-018 Load accepted, flush_in one cycle later, ack 3 cycles later -> bus_req_out held through ack, no resp_valid_out, req_ready_out=1 the cycle after ack.
REQ-019 rst asserted mid-BUS -> next cycle bus_req_out=0, req_ready_out=1, all REQ-013 outputs at reset values. Pass-through with addr_in=0x55 -> resp_valid_out next cycle, rd_value_out=0x55, no bus activity.
